// File: rtl/spi_multi_lane_master_if.sv
// Bundle of the control handshake, receive results and SPI pins of
// spi_multi_lane_master. The master modport is the SPI master's view of the bundle.
// The slave modport is the view of the register logic and board that connect to it.
interface spi_multi_lane_master_if #(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 32
);
    logic                        start;
    logic                        cpol;
    logic                        cpha;
    logic [N_LANES*DATA_W-1:0]   tx_data;
    logic                        busy;
    logic                        done;
    logic [N_LANES*DATA_W-1:0]   rx_data;
    logic                        rx_valid;
    logic                        SPISCLKO;
    logic                        SPISSN;
    logic [N_LANES-1:0]          SPISDO;
    logic [N_LANES-1:0]          SPISDI;

    modport master (
        input  start, cpol, cpha, tx_data, SPISDI,
        output busy, done, rx_data, rx_valid, SPISCLKO, SPISSN, SPISDO
    );

    modport slave (
        output start, cpol, cpha, tx_data, SPISDI,
        input  busy, done, rx_data, rx_valid, SPISCLKO, SPISSN, SPISDO
    );
endinterface

// File: rtl/spi_multi_lane_master.sv
// Multi-lane SPI master: N_LANES MOSI/MISO lanes shift in lockstep, MSB first.
// All lanes share one SCLK and one chip select. CPOL and CPHA are chosen at run time.
// A transfer runs LEAD (H cycles), then SHIFT (2*DATA_W half-periods of H cycles),
// then TRAIL (H cycles). H is CLK_DIV.
module spi_multi_lane_master #(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                    PCLK,
    input  logic                    PRESETN,
    spi_multi_lane_master_if.master bus
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HP_W  = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST    = HP_W'(2 * DATA_W - 1);
    // Half-period index at whose end the final trailing edge occurs
    localparam logic [HP_W-1:0]  HP_LAST_TR = HP_W'(2 * DATA_W - 2);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;
    typedef logic [N_LANES-1:0][DATA_W-1:0] lanes_t;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [HP_W-1:0]    hp_cnt_q, hp_cnt_d;
    logic               cpha_q, cpha_d;
    logic               sclk_q, sclk_d;
    logic               ssn_q, ssn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rx_valid_q, rx_valid_d;
    lanes_t             tx_sh_q, tx_sh_d;
    lanes_t             rx_sh_q, rx_sh_d;
    lanes_t             rx_data_q, rx_data_d;

    logic               hp_end;
    logic               sclk_edge;
    logic               lead_edge;
    logic               sample;
    logic               advance;
    logic [N_LANES-1:0] sdo;

    // Next-state, SCLK edge scheduling and lane shifting
    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        hp_cnt_d   = hp_cnt_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        ssn_d      = ssn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_valid_d = rx_valid_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sclk_edge  = 1'b0;
        lead_edge  = 1'b0;
        sample     = 1'b0;
        advance    = 1'b0;

        hp_end = (div_cnt_q == CNT_LAST);
        if (state_q == IDLE) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = hp_end ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LEAD;
                    tx_sh_d    = bus.tx_data;
                    cpha_d     = bus.cpha;
                    sclk_d     = bus.cpol;
                    ssn_d      = 1'b0;
                    busy_d     = 1'b1;
                    rx_valid_d = 1'b0;
                end
            end
            LEAD: begin
                if (hp_end) begin
                    state_d   = SHIFT;
                    hp_cnt_d  = '0;
                    sclk_edge = 1'b1;
                    lead_edge = 1'b1;
                end
            end
            SHIFT: begin
                if (hp_end) begin
                    if (hp_cnt_q == HP_LAST) begin
                        state_d = TRAIL;
                    end else begin
                        hp_cnt_d  = hp_cnt_q + 1'b1;
                        sclk_edge = 1'b1;
                        // Entering half-period n+1 makes edge n+2; odd edges lead
                        lead_edge = hp_cnt_q[0];
                    end
                end
            end
            TRAIL: begin
                if (hp_end) begin
                    state_d    = IDLE;
                    ssn_d      = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sclk_edge) begin
            sclk_d = ~sclk_q;
            // cpha=0 samples on leading edges, cpha=1 on trailing edges
            sample = (lead_edge != cpha_q);
            // The MSB is already on MOSI from LEAD, so the first leading edge never shifts.
            // With cpha=0 the final trailing edge leaves the LSB in place through TRAIL.
            advance = (state_q == SHIFT) &&
                      (cpha_q ? lead_edge : (!lead_edge && hp_cnt_q != HP_LAST_TR));
        end

        for (int i = 0; i < N_LANES; i++) begin
            if (advance) tx_sh_d[i] = {tx_sh_q[i][DATA_W-2:0], 1'b0};
            if (sample)  rx_sh_d[i] = {rx_sh_q[i][DATA_W-2:0], bus.SPISDI[i]};
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            hp_cnt_q   <= '0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ssn_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            // NOTE: the lane shift registers are reset as well, because SPISDO comes straight from them.
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop loads a value computed from pre-edge state.
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            hp_cnt_q   <= hp_cnt_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            ssn_q      <= ssn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // MOSI is the MSB of each lane's transmit shift register
    always_comb begin
        sdo = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sdo[i] = tx_sh_q[i][DATA_W-1];
        end
    end

    assign bus.SPISDO   = sdo;
    assign bus.SPISCLKO = sclk_q;
    assign bus.SPISSN   = ssn_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_multi_lane_master.sv
// Self-checking bench for spi_multi_lane_master.
// It drives a small instance (2 lanes, 8 bits, H=2) and a default instance (2 lanes, 32 bits, H=4).
// Each expected receive word is queued when its transfer starts.
// The word is checked against the DUT's done pulse.
module tb_spi_multi_lane_master;
    localparam int NL   = 2;
    localparam int DW   = 8;
    localparam int H    = 2;
    localparam int DW_D = 32;
    localparam int W    = NL * DW;

    logic PCLK    = 1'b0;
    logic PRESETN = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 PCLK = ~PCLK;

    spi_multi_lane_master_if #(.N_LANES(NL), .DATA_W(DW))   sif ();
    spi_multi_lane_master_if #(.N_LANES(NL), .DATA_W(DW_D)) dif ();

    spi_multi_lane_master #(.N_LANES(NL), .DATA_W(DW), .CLK_DIV(H)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (sif.master)
    );

    spi_multi_lane_master dut_dflt (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .bus     (dif.master)
    );

    // MISO source for the small instance: loopback or the model slave
    logic          loopback  = 1'b1;
    logic          slv_cpol  = 1'b0;
    logic [DW-1:0] slv_word [NL];
    logic [DW-1:0] slv_sh   [NL];
    logic [NL-1:0] slave_sdo = '0;
    logic          ssn_seen  = 1'b1;
    logic          sclk_seen = 1'b0;

    assign sif.SPISDI = loopback ? sif.SPISDO : slave_sdo;
    assign dif.SPISDI = dif.SPISDO;

    // Model slave (cpha=1 style): load reply at chip-select fall, present next bit on each leading edge
    always @(sif.SPISSN or sif.SPISCLKO) begin
        if (ssn_seen && !sif.SPISSN) begin
            for (int i = 0; i < NL; i++) slv_sh[i] = slv_word[i];
        end else if (!sif.SPISSN && sif.SPISCLKO != sclk_seen && sif.SPISCLKO != slv_cpol) begin
            for (int i = 0; i < NL; i++) begin
                slave_sdo[i] = slv_sh[i][DW-1];
                slv_sh[i]    = slv_sh[i] << 1;
            end
        end
        ssn_seen  = sif.SPISSN;
        sclk_seen = sif.SPISCLKO;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued expectation
    logic [W-1:0] exp_q [$];
    logic [W-1:0] sb_exp;

    always @(negedge PCLK) begin
        if (sif.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(sif.done), 64'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_rx_data",  64'(sif.rx_data),  64'(sb_exp));
                check("sb_rx_valid", 64'(sif.rx_valid), 64'd1);
                check("sb_busy_low", 64'(sif.busy),     64'd0);
                check("sb_ssn_high", 64'(sif.SPISSN),   64'd1);
            end
        end
    end

    // One transfer on the small instance, entered and left on a negedge.
    // It counts chip-select-low cycles, SCLK rising edges and done pulses.
    // A second start pulse is injected at loop cycle extra_at, with altered tx_data.
    task automatic run_small(input logic pol, input logic pha, input logic [W-1:0] tx,
                             input logic [W-1:0] expect_rx, input int extra_at,
                             output int low, output int rises, output int dones);
        logic prev;
        sif.cpol    = pol;
        sif.cpha    = pha;
        sif.tx_data = tx;
        sif.start   = 1'b1;
        exp_q.push_back(expect_rx);
        low   = 0;
        rises = 0;
        dones = 0;
        prev  = sif.SPISCLKO;
        @(negedge PCLK);
        for (int c = 0; c < 200 && dones == 0; c++) begin
            sif.start = (c == extra_at);
            if (c == extra_at) sif.tx_data = ~tx;
            if (sif.SPISSN == 1'b0) low++;
            if (!prev && sif.SPISCLKO) rises++;
            prev = sif.SPISCLKO;
            if (sif.done) dones++;
            @(negedge PCLK);
        end
        sif.start = 1'b0;
    endtask

    initial begin
        int             low;
        int             rises;
        int             dones;
        int             got;
        logic           prev;
        logic [31:0]    cap0;
        logic [31:0]    cap1;
        logic [63:0]    dtx;

        sif.start = 1'b0; sif.cpol = 1'b0; sif.cpha = 1'b0; sif.tx_data = '0;
        dif.start = 1'b0; dif.cpol = 1'b0; dif.cpha = 1'b0; dif.tx_data = '0;
        slv_word[0] = 8'h3C;
        slv_word[1] = 8'hC3;

        // Reset values
        #2 PRESETN = 1'b0;
        #1;
        check("rst_busy",     64'(sif.busy),     64'd0);
        check("rst_done",     64'(sif.done),     64'd0);
        check("rst_rx_valid", 64'(sif.rx_valid), 64'd0);
        check("rst_rx_data",  64'(sif.rx_data),  64'd0);
        check("rst_ssn",      64'(sif.SPISSN),   64'd1);
        check("rst_sclk",     64'(sif.SPISCLKO), 64'd0);
        check("rst_sdo",      64'(sif.SPISDO),   64'd0);
        check("rst_dflt_ssn", 64'(dif.SPISSN),   64'd1);
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);

        // Mode 0 loopback
        run_small(1'b0, 1'b0, 16'hA55A, 16'hA55A, -1, low, rises, dones);
        check("m0_ssn_low_cycles", 64'(low),   64'd36);
        check("m0_sclk_rises",     64'(rises), 64'd8);
        check("m0_done_pulses",    64'(dones), 64'd1);
        check("m0_rx_valid_after", 64'(sif.rx_valid), 64'd1);
        check("m0_sclk_idle_low",  64'(sif.SPISCLKO), 64'd0);
        repeat (2) @(negedge PCLK);

        // Mode 3 against the model slave
        loopback = 1'b0;
        slv_cpol = 1'b1;
        run_small(1'b1, 1'b1, 16'h0F0F, {slv_word[1], slv_word[0]}, -1, low, rises, dones);
        check("m3_ssn_low_cycles", 64'(low),   64'd36);
        check("m3_done_pulses",    64'(dones), 64'd1);
        repeat (2) @(negedge PCLK);
        check("m3_sclk_idle_high", 64'(sif.SPISCLKO), 64'd1);
        loopback = 1'b1;

        // Mode 2 loopback, starting from an idle-high SCLK
        check("m2_sclk_high_before", 64'(sif.SPISCLKO), 64'd1);
        run_small(1'b1, 1'b0, 16'h3C96, 16'h3C96, -1, low, rises, dones);
        check("m2_done_pulses", 64'(dones), 64'd1);
        repeat (2) @(negedge PCLK);

        // A second start while busy is ignored
        run_small(1'b0, 1'b1, 16'h81E7, 16'h81E7, 2, low, rises, dones);
        check("ign_done_pulses",   64'(dones), 64'd1);
        check("ign_ssn_low",       64'(low),   64'd36);
        check("ign_busy_after",    64'(sif.busy),   64'd0);
        check("ign_ssn_after",     64'(sif.SPISSN), 64'd1);
        repeat (2) @(negedge PCLK);

        // Back-to-back: start held high through the done cycle
        sif.cpol    = 1'b0;
        sif.cpha    = 1'b1;
        sif.tx_data = 16'h1234;
        sif.start   = 1'b1;
        exp_q.push_back(16'h1234);
        got = 0;
        for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge PCLK);
            if (sif.done) got = 1;
        end
        check("b2b_first_done",   64'(got),        64'd1);
        check("b2b_ssn_high_gap", 64'(sif.SPISSN), 64'd1);
        sif.tx_data = 16'h5AC3;
        exp_q.push_back(16'h5AC3);
        @(negedge PCLK);
        sif.start = 1'b0;
        check("b2b_ssn_low_next",   64'(sif.SPISSN),   64'd0);
        check("b2b_rx_valid_drop",  64'(sif.rx_valid), 64'd0);
        check("b2b_busy_next",      64'(sif.busy),     64'd1);
        got = 0;
        for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge PCLK);
            if (sif.done) got = 1;
        end
        check("b2b_second_done", 64'(got), 64'd1);
        repeat (3) @(negedge PCLK);

        // Reset in the middle of SHIFT
        sif.cpol    = 1'b0;
        sif.cpha    = 1'b0;
        sif.tx_data = 16'hF00F;
        sif.start   = 1'b1;
        @(negedge PCLK);
        sif.start = 1'b0;
        repeat (18) @(negedge PCLK);
        check("mid_ssn_low_pre", 64'(sif.SPISSN), 64'd0);
        check("mid_busy_pre",    64'(sif.busy),   64'd1);
        PRESETN = 1'b0;
        #1;
        check("mid_rst_busy",     64'(sif.busy),     64'd0);
        check("mid_rst_done",     64'(sif.done),     64'd0);
        check("mid_rst_ssn",      64'(sif.SPISSN),   64'd1);
        check("mid_rst_sclk",     64'(sif.SPISCLKO), 64'd0);
        check("mid_rst_sdo",      64'(sif.SPISDO),   64'd0);
        check("mid_rst_rx_valid", 64'(sif.rx_valid), 64'd0);
        check("mid_rst_rx_data",  64'(sif.rx_data),  64'd0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        dones = 0;
        low   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (sif.done) dones++;
            if (!sif.SPISSN) low++;
        end
        check("mid_no_done",        64'(dones), 64'd0);
        check("mid_ssn_stays_high", 64'(low),   64'd0);
        check("mid_rx_valid_low",   64'(sif.rx_valid), 64'd0);

        // Fresh transfer after the abort
        run_small(1'b0, 1'b0, 16'h6E19, 16'h6E19, -1, low, rises, dones);
        check("fresh_done_pulses", 64'(dones), 64'd1);
        check("fresh_ssn_low",     64'(low),   64'd36);
        repeat (2) @(negedge PCLK);

        // Default instance: serialisation order and transfer length
        dtx = {32'h12345678, 32'hAABB0134};
        dif.cpol    = 1'b0;
        dif.cpha    = 1'b0;
        dif.tx_data = dtx;
        dif.start   = 1'b1;
        prev  = dif.SPISCLKO;
        low   = 0;
        rises = 0;
        dones = 0;
        cap0  = '0;
        cap1  = '0;
        @(negedge PCLK);
        dif.start = 1'b0;
        for (int c = 0; c < 400 && dones == 0; c++) begin
            if (!dif.SPISSN) low++;
            if (!prev && dif.SPISCLKO) begin
                rises++;
                cap0 = {cap0[30:0], dif.SPISDO[0]};
                cap1 = {cap1[30:0], dif.SPISDO[1]};
            end
            prev = dif.SPISCLKO;
            if (dif.done) dones++;
            @(negedge PCLK);
        end
        check("dflt_ssn_low_cycles", 64'(low),   64'd264);
        check("dflt_sclk_rises",     64'(rises), 64'd32);
        check("dflt_done_pulses",    64'(dones), 64'd1);
        check("dflt_lane0_serial",   64'(cap0),  64'(dtx[31:0]));
        check("dflt_lane1_serial",   64'(cap1),  64'(dtx[63:32]));
        check("dflt_rx_loopback",    64'(dif.rx_data), dtx);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
